sync_frame_tx: RTL

Serial frame transmitter that produces the bitstream consumed by the team's consecutive-ones sync detector. It accepts a parallel word through a valid/ready handshake. It emits a sync preamble of SYNC_LEN ones, a separator zero, and the payload MSB-first with zero-bit stuffing, so no payload run of ones can fake a sync. It sits between the control logic and the serial line feeding the receiver-side detector.

---
 rtl/sync_frame_tx.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/sync_frame_tx.sv
// -----------------------------------------------------------------------------
// sync_frame_tx
//
// Serial frame transmitter feeding the consecutive-ones sync detector. A word
// accepted on the LOAD/READY handshake is sent as:
//    SYNC_LEN ones | one separator zero | payload MSB-first, zero-stuffed
// A zero is inserted after every STUFF_RUN consecutive payload ones, so the
// payload can never contain a run long enough to fake the preamble.
//
// Parameters:
//    SYNC_LEN   preamble length in ones; must match the detector run length
//    DATA_W     payload width in bits (>= 1)
//    STUFF_RUN  payload ones allowed before a stuffed zero (1 .. SYNC_LEN-2)
//
// Ports:
//    CLK         in   clock, rising edge
//    RST         in   asynchronous reset, active high
//    DIN         in   payload word, captured on accept
//    LOAD        in   send request; accepted when READY is high at a rising edge
//    READY       out  high only while idle
//    SOUT        out  registered serial line, low when idle
//    BUSY        out  high while a frame is on the line
//    FRAME_DONE  out  one-cycle pulse in the first idle cycle after a frame
//
// Build option:
//    SYNC_FRAME_TX_PARITY_EN  when defined, an even-parity bit (XOR of the
//                             payload bits) follows the payload. It counts
//                             toward the ones run and may itself be stuffed.
// -----------------------------------------------------------------------------
module sync_frame_tx #(
   parameter int SYNC_LEN  = 10,
   parameter int DATA_W    = 8,
   parameter int STUFF_RUN = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] DIN,
   input  logic              LOAD,
   output logic              READY,
   output logic              SOUT,
   output logic              BUSY,
   output logic              FRAME_DONE
);

   localparam int SYNC_W = $clog2(SYNC_LEN + 1);
   localparam int BIT_W  = $clog2(DATA_W + 1);
   localparam int RUN_W  = $clog2(STUFF_RUN + 1);

   localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_LEN - 1);
   localparam logic [BIT_W-1:0]  BITS_ALL  = BIT_W'(DATA_W);
   localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(STUFF_RUN);

   // Each state names the bit currently driven on SOUT.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_SEP,
      ST_DATA,
      ST_STUFF
`ifdef SYNC_FRAME_TX_PARITY_EN
      , ST_PAR
`endif
   } state_t;

   state_t            state_q;
   logic [DATA_W-1:0] shreg_q;
   logic [SYNC_W-1:0] sync_cnt_q;   // sync ones still to send after this one
   logic [BIT_W-1:0]  bit_cnt_q;    // payload bits not yet sent
   logic [RUN_W-1:0]  run_q;        // consecutive ones sent since last zero
   logic              sout_q;
   logic              ready_q;
   logic              busy_q;
   logic              done_q;
`ifdef SYNC_FRAME_TX_PARITY_EN
   logic              par_q;        // even parity of the captured word
   logic              par_sent_q;   // parity bit already on the line
   logic [RUN_W-1:0]  run_par_d;
`endif

   logic              data_bit;
   logic [RUN_W-1:0]  run_data_d;
   logic [DATA_W-1:0] shreg_d;

   assign data_bit   = shreg_q[DATA_W-1];
   assign run_data_d = data_bit ? run_q + 1'b1 : '0;
   assign shreg_d    = shreg_q << 1;
`ifdef SYNC_FRAME_TX_PARITY_EN
   assign run_par_d  = par_q ? run_q + 1'b1 : '0;
`endif

   assign READY      = ready_q;
   assign SOUT       = sout_q;
   assign BUSY       = busy_q;
   assign FRAME_DONE = done_q;

   // NOTE: every state element here is written with <= so all registers update
   // from the same pre-edge values; blocking writes would leak new values into
   // later decisions within the same edge.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         // NOTE: the shift register is reset along with the control state so an
         // abandoned frame leaves no stale payload behind.
         shreg_q    <= '0;
         sync_cnt_q <= '0;
         bit_cnt_q  <= '0;
         run_q      <= '0;
         sout_q     <= 1'b0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef SYNC_FRAME_TX_PARITY_EN
         par_q      <= 1'b0;
         par_sent_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // READY is high exactly in this state, so LOAD alone is an accept.
               if (LOAD) begin
                  state_q    <= ST_SYNC;
                  shreg_q    <= DIN;
                  sync_cnt_q <= SYNC_LAST;
                  bit_cnt_q  <= BITS_ALL;
                  run_q      <= '0;
                  sout_q     <= 1'b1;
                  ready_q    <= 1'b0;
                  busy_q     <= 1'b1;
`ifdef SYNC_FRAME_TX_PARITY_EN
                  par_q      <= ^DIN;
                  par_sent_q <= 1'b0;
`endif
               end
            end

            ST_SYNC: begin
               if (sync_cnt_q == '0) begin
                  state_q <= ST_SEP;
                  sout_q  <= 1'b0;
                  run_q   <= '0;
               end else begin
                  sync_cnt_q <= sync_cnt_q - 1'b1;
               end
            end

            ST_SEP: begin
               state_q   <= ST_DATA;
               sout_q    <= data_bit;
               shreg_q   <= shreg_d;
               bit_cnt_q <= bit_cnt_q - 1'b1;
               run_q     <= run_data_d;
            end

            ST_DATA: begin
               if (run_q == RUN_MAX) begin
                  // The bit just sent completed a run: break it before anything else.
                  state_q <= ST_STUFF;
                  sout_q  <= 1'b0;
                  run_q   <= '0;
               end else if (bit_cnt_q != '0) begin
                  sout_q    <= data_bit;
                  shreg_q   <= shreg_d;
                  bit_cnt_q <= bit_cnt_q - 1'b1;
                  run_q     <= run_data_d;
               end else begin
`ifdef SYNC_FRAME_TX_PARITY_EN
                  state_q    <= ST_PAR;
                  sout_q     <= par_q;
                  run_q      <= run_par_d;
                  par_sent_q <= 1'b1;
`else
                  state_q <= ST_IDLE;
                  sout_q  <= 1'b0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
`endif
               end
            end

            ST_STUFF: begin
               if (bit_cnt_q != '0) begin
                  state_q   <= ST_DATA;
                  sout_q    <= data_bit;
                  shreg_q   <= shreg_d;
                  bit_cnt_q <= bit_cnt_q - 1'b1;
                  run_q     <= run_data_d;
`ifdef SYNC_FRAME_TX_PARITY_EN
               end else if (!par_sent_q) begin
                  state_q    <= ST_PAR;
                  sout_q     <= par_q;
                  run_q      <= run_par_d;
                  par_sent_q <= 1'b1;
`endif
               end else begin
                  state_q <= ST_IDLE;
                  sout_q  <= 1'b0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end

`ifdef SYNC_FRAME_TX_PARITY_EN
            ST_PAR: begin
               if (run_q == RUN_MAX) begin
                  state_q <= ST_STUFF;
                  sout_q  <= 1'b0;
                  run_q   <= '0;
               end else begin
                  state_q <= ST_IDLE;
                  sout_q  <= 1'b0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
`endif

            // NOTE: unused encodings fall back to idle so the FSM can never lock up.
            default: begin
               state_q <= ST_IDLE;
               sout_q  <= 1'b0;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
